pwm_duty_ramp_ctrl: RTL and testbench
=====================================

Name: pwm_duty_ramp_ctrl

Overview:
- Controller that sequences the 12-bit PWM duty word written by the CPU through the Avalon PIO output port.
- Samples the target duty only at PWM period boundaries, so mid-period CPU writes cannot glitch the output.
- Slews the applied duty toward the target by a programmable step per period.
- Generates the prescaled PWM waveform; on disable, ramps down to zero before going idle (soft start / soft stop).

Parameters:
- DUTY_W, 12: duty and period-counter width; period = 2^DUTY_W - 1 ticks.
- PRESCALE_W, 16: prescaler reload width.
- STEP_W, 8: ramp step width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run request; level-sensitive.
- duty_target  in  DUTY_W  target duty from the PIO out_port; may change on any cycle.
- step  in  STEP_W  duty change per period; 0 = jump directly to target.
- prescale  in  PRESCALE_W  one tick every prescale+1 clk cycles.
- pwm_out  out  1  registered PWM output.
- duty_now  out  DUTY_W  duty currently applied.
- period_tick  out  1  one-clk pulse at each period end.
- ramp_busy  out  1  active and duty_now != latched target.
- active  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state=IDLE, cnt=0, presc_cnt=0, duty_now=0, tgt_q=0, pwm_out=0, period_tick=0, ramp_busy=0, active=0.
- Reset asserted mid-operation: reset values take effect on the next edge regardless of state.
- Prescaler:
  - presc_cnt counts 0..prescale; tick=1 when presc_cnt==prescale, then presc_cnt reloads 0.
  - prescale=0 gives a tick every cycle.
  - A prescale change takes effect at the next tick; if the new value is below presc_cnt, the count wraps through 2^PRESCALE_W.
- Period counter:
  - In RUN/STOP, cnt advances on tick over 0..2^DUTY_W-2 (0..4094), giving 4095 ticks per period.
  - Period end = tick && cnt==4094: cnt wraps to 0 and period_tick=1 for that one cycle.
- PWM output: pwm_out <= active && (cnt < duty_now), registered, 1-cycle latency.
  - duty 0: constant low.
  - duty 4095: constant high.
- Ramp update, at period end only (all arithmetic in DUTY_W+1 bits, saturating at target):
  - tgt_q <= duty_target in RUN; the effective target is 0 in STOP.
  - If duty_now < tgt: duty_now <= min(duty_now+step, tgt).
  - If duty_now > tgt: duty_now <= max(duty_now-step, tgt).
  - step=0: duty_now <= tgt.
  - The new duty_now applies from cnt=0 of the next period.
- FSM:
  - IDLE: cnt, presc_cnt and duty_now held at 0. When enable=1: go to RUN, with counters starting from 0 on the next cycle.
  - RUN: when enable=0: go to STOP (counters continue, no restart).
  - STOP: ramps toward 0. When enable=1: back to RUN, keeping current duty_now and cnt.
  - STOP: at the period end where duty_now is already 0, go to IDLE.
  - STOP with step=0: duty_now jumps to 0 at the next period end, then IDLE at the following period end.
- Status:
  - ramp_busy = active && (duty_now != effective target).
  - duty_target changes mid-period have no effect until the next period end.

Decomposition:
- Shared package pwm_ctrl_pkg holds:
  - FSM state enum: IDLE, RUN, STOP.
  - Constants: DUTY_W=12, PERIOD_MAX=2^DUTY_W-2.
  - Function sat_step(cur, tgt, step) returning the next duty.
- One natural sub-module, pwm_prescaler: presc_cnt plus tick generation.
- Everything else (FSM, counter, ramp, compare) stays in the top block.

Test Plan:
- Soft start, direct jump: prescale=0, step=0, duty_target=1000, enable raised.
  - First period pwm_out low.
  - period_tick every 4095 clk.
  - Second period pwm_out high exactly 1000 clk, low 3095 clk.
- Ramp up: step=100, duty_target=350.
  - duty_now reads 100, 200, 300, 350 after successive period_ticks.
  - ramp_busy drops with the 350 update.
- Soft stop: from duty_now=350 with step=100, drop enable.
  - duty_now reads 250, 150, 50, 0 after successive period_ticks.
  - active=0 one period later; pwm_out stays 0.
- Boundary duties and prescaler: duty_target=4095 gives pwm_out constantly 1; duty_target=0 gives constantly 0.
  - prescale=3 gives period_tick spacing of 16380 clk.
- Mid-period write: change duty_target 1000→2000 at cnt=500.
  - Current period still applies 1000; 2000 applies from the next cnt=0 (step=0).
- Reset mid-run: assert reset for 1 cycle while in RUN with duty_now=2000.
  - Next cycle all outputs 0 and state IDLE.
  - With enable still high, RUN resumes with duty_now starting from 0.

Source files
------------

// File: rtl/pwm_ctrl_pkg.sv
// Shared types, widths and the saturating ramp helper for the PWM duty ramp controller.
package pwm_ctrl_pkg;

    localparam int DUTY_W     = 12;
    localparam int PRESCALE_W = 16;
    localparam int STEP_W     = 8;

    // Last counter value of a period; a period is 2^DUTY_W - 1 ticks long.
    localparam logic [DUTY_W-1:0] PERIOD_MAX = DUTY_W'((2 ** DUTY_W) - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_e;

    // Move cur toward tgt by at most step; step == 0 jumps straight to tgt.
    // Arithmetic is one bit wider than the duty so the sum cannot overflow.
    function automatic logic [DUTY_W-1:0] sat_step(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] tgt,
        input logic [STEP_W-1:0] step
    );
        logic [DUTY_W:0] cur_x;
        logic [DUTY_W:0] tgt_x;
        logic [DUTY_W:0] step_x;
        logic [DUTY_W:0] gap;
        logic [DUTY_W:0] res;
        cur_x  = {1'b0, cur};
        tgt_x  = {1'b0, tgt};
        step_x = {{(DUTY_W + 1 - STEP_W){1'b0}}, step};
        gap    = '0;
        res    = cur_x;
        if (step == '0) begin
            res = tgt_x;
        end else if (cur_x < tgt_x) begin
            gap = tgt_x - cur_x;
            res = (gap <= step_x) ? tgt_x : (cur_x + step_x);
        end else if (cur_x > tgt_x) begin
            gap = cur_x - tgt_x;
            res = (gap <= step_x) ? tgt_x : (cur_x - step_x);
        end else begin
            res = cur_x;
        end
        return res[DUTY_W-1:0];
    endfunction

endpackage

// File: rtl/pwm_duty_ramp_ctrl_if.sv
// Control/status bundle between the CPU-side PIO registers and the PWM ramp controller.
interface pwm_duty_ramp_ctrl_if;
    import pwm_ctrl_pkg::*;

    logic                  enable;
    logic [DUTY_W-1:0]     duty_target;
    logic [STEP_W-1:0]     step;
    logic [PRESCALE_W-1:0] prescale;
    logic                  pwm_out;
    logic [DUTY_W-1:0]     duty_now;
    logic                  period_tick;
    logic                  ramp_busy;
    logic                  active;

    modport master (
        output enable, duty_target, step, prescale,
        input  pwm_out, duty_now, period_tick, ramp_busy, active
    );

    modport slave (
        input  enable, duty_target, step, prescale,
        output pwm_out, duty_now, period_tick, ramp_busy, active
    );
endinterface

// File: rtl/pwm_prescaler.sv
// Tick generator: one tick every prescale+1 clocks while running, held at zero otherwise.
module pwm_prescaler
    import pwm_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  tick_o
);

    logic [PRESCALE_W-1:0] presc_cnt_q;
    logic [PRESCALE_W-1:0] presc_cnt_d;

    // Compared against the live reload value: a reload lowered below the
    // current count simply lets the counter wrap before the next tick.
    assign tick_o = run_i && (presc_cnt_q == prescale_i);

    // Next prescaler count: clear when stopped or on tick, else increment.
    always_comb begin
        presc_cnt_d = presc_cnt_q;
        if (!run_i) begin
            presc_cnt_d = '0;
        end else if (tick_o) begin
            presc_cnt_d = '0;
        end else begin
            presc_cnt_d = presc_cnt_q + PRESCALE_W'(1);
        end
    end

    // Prescaler count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_cnt_q <= '0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
        end
    end

endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// PWM duty ramp controller: period counter, boundary-latched target, slew-limited
// duty, soft start/stop FSM and registered PWM compare.
module pwm_duty_ramp_ctrl
    import pwm_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    pwm_duty_ramp_ctrl_if.slave  bus
);

    state_e            state_q, state_d;
    logic [DUTY_W-1:0] cnt_q, cnt_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] tgt_q, tgt_d;
    logic [DUTY_W-1:0] eff_tgt_d;
    logic              pwm_q, pwm_d;
    logic              ptick_q, ptick_d;
    logic              busy_q, busy_d;
    logic              active_q, active_d;
    logic              run_s;
    logic              tick_s;
    logic              period_end_s;

    assign run_s        = (state_q != IDLE);
    assign period_end_s = tick_s && (cnt_q == PERIOD_MAX);

    pwm_prescaler u_prescaler (
        .clk        (clk),
        .reset      (reset),
        .run_i      (run_s),
        .prescale_i (bus.prescale),
        .tick_o     (tick_s)
    );

    // Next-state logic: FSM, period counter, target latch and duty ramp.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        duty_d  = duty_q;
        tgt_d   = tgt_q;
        if (tick_s) begin
            cnt_d = period_end_s ? '0 : (cnt_q + DUTY_W'(1));
        end else begin
            cnt_d = cnt_q;
        end
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                duty_d  = '0;
                state_d = bus.enable ? RUN : IDLE;
            end
            RUN: begin
                // The target is only sampled here so mid-period writes never glitch the waveform.
                if (period_end_s) begin
                    tgt_d  = bus.duty_target;
                    duty_d = sat_step(duty_q, bus.duty_target, bus.step);
                end else begin
                    duty_d = duty_q;
                end
                state_d = bus.enable ? RUN : STOP;
            end
            STOP: begin
                if (period_end_s && (duty_q != '0)) begin
                    duty_d = sat_step(duty_q, '0, bus.step);
                end else begin
                    duty_d = duty_q;
                end
                if (bus.enable) begin
                    state_d = RUN;
                end else if (period_end_s && (duty_q == '0)) begin
                    state_d = IDLE;
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                duty_d  = '0;
            end
        endcase
        eff_tgt_d = (state_d == RUN) ? tgt_d : '0;
        active_d  = (state_d != IDLE);
        busy_d    = active_d && (duty_d != eff_tgt_d);
        ptick_d   = period_end_s;
        pwm_d     = run_s && (cnt_q < duty_q);
    end

    // State and registered outputs, all cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            duty_q   <= '0;
            tgt_q    <= '0;
            pwm_q    <= 1'b0;
            ptick_q  <= 1'b0;
            busy_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            duty_q   <= duty_d;
            tgt_q    <= tgt_d;
            pwm_q    <= pwm_d;
            ptick_q  <= ptick_d;
            busy_q   <= busy_d;
            active_q <= active_d;
        end
    end

    assign bus.pwm_out     = pwm_q;
    assign bus.duty_now    = duty_q;
    assign bus.period_tick = ptick_q;
    assign bus.ramp_busy   = busy_q;
    assign bus.active      = active_q;

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Directed, table-driven bench for pwm_duty_ramp_ctrl.
module tb_pwm_duty_ramp_ctrl;
    import pwm_ctrl_pkg::*;

    localparam int WAIT_MAX = 70000;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pwm_duty_ramp_ctrl_if bus ();

    pwm_duty_ramp_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic        en;
        logic [11:0] tgt;
        logic [7:0]  step;
        int          exp_duty;
        int          exp_busy;
        int          exp_active;
        int          exp_highs;
        int          exp_len;   // -1: period length not checked
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Count clocks and high pwm samples up to and including the next period_tick.
    // Optionally rewrites duty_target at sample index sw_at (0 = never).
    task automatic run_period(input int sw_at, input logic [11:0] sw_tgt,
                              output int len, output int highs);
        bit done;
        done  = 1'b0;
        len   = 0;
        highs = 0;
        for (int i = 0; i < WAIT_MAX; i++) begin
            @(negedge clk);
            len++;
            if (bus.pwm_out) highs++;
            if (len == sw_at) bus.duty_target = sw_tgt;
            if (bus.period_tick) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_total++;
            $display("FAIL period_wait: no period_tick within %0d cycles", WAIT_MAX);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pwm"},    int'(bus.pwm_out), 0);
        check({tag, "_duty"},   int'(bus.duty_now), 0);
        check({tag, "_ptick"},  int'(bus.period_tick), 0);
        check({tag, "_busy"},   int'(bus.ramp_busy), 0);
        check({tag, "_active"}, int'(bus.active), 0);
    endtask

    initial begin
        int len;
        int highs;

        // en, tgt, step, duty, busy, active, highs in the period just ended, len
        vecs[0]  = '{1'b1, 12'd350,  8'd100, 100,  1, 1, 0,    -1};
        vecs[1]  = '{1'b1, 12'd350,  8'd100, 200,  1, 1, 100,  4095};
        vecs[2]  = '{1'b1, 12'd350,  8'd100, 300,  1, 1, 200,  4095};
        vecs[3]  = '{1'b1, 12'd350,  8'd100, 350,  0, 1, 300,  4095};
        vecs[4]  = '{1'b0, 12'd350,  8'd100, 250,  1, 1, 350,  4095};
        vecs[5]  = '{1'b0, 12'd350,  8'd100, 150,  1, 1, 250,  4095};
        vecs[6]  = '{1'b0, 12'd350,  8'd100, 50,   1, 1, 150,  4095};
        vecs[7]  = '{1'b0, 12'd350,  8'd100, 0,    0, 1, 50,   4095};
        vecs[8]  = '{1'b0, 12'd350,  8'd100, 0,    0, 0, 0,    4095};
        vecs[9]  = '{1'b1, 12'd4095, 8'd0,   4095, 0, 1, 0,    -1};
        vecs[10] = '{1'b1, 12'd0,    8'd0,   0,    0, 1, 4095, 4095};
        vecs[11] = '{1'b1, 12'd0,    8'd0,   0,    0, 1, 0,    4095};

        reset           = 1'b1;
        bus.enable      = 1'b0;
        bus.duty_target = 12'd0;
        bus.step        = 8'd0;
        bus.prescale    = 16'd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Soft start with a direct jump to 1000.
        bus.enable      = 1'b1;
        bus.duty_target = 12'd1000;
        bus.step        = 8'd0;
        run_period(0, 12'd0, len, highs);
        check("start_first_highs", highs, 0);
        check("start_duty", int'(bus.duty_now), 1000);
        check("start_busy", int'(bus.ramp_busy), 0);
        run_period(0, 12'd0, len, highs);
        check("start_len", len, 4095);
        check("start_highs", highs, 1000);

        // Mid-period write lands only at the next boundary.
        run_period(500, 12'd2000, len, highs);
        check("midwr_len", len, 4095);
        check("midwr_highs", highs, 1000);
        check("midwr_duty", int'(bus.duty_now), 2000);

        // prescale = 3: four clocks per tick.
        bus.prescale = 16'd3;
        run_period(0, 12'd0, len, highs);
        check("presc_len", len, 16380);
        check("presc_highs", highs, 8000);
        check("presc_duty", int'(bus.duty_now), 2000);

        // Reset while running.
        bus.prescale = 16'd0;
        repeat (50) @(negedge clk);
        check("prerst_active", int'(bus.active), 1);
        check("prerst_duty", int'(bus.duty_now), 2000);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_all_zero("midrst");
        @(negedge clk);
        check("rerun_active", int'(bus.active), 1);
        check("rerun_duty", int'(bus.duty_now), 0);

        // Ramp up, soft stop to idle, boundary duties.
        for (int i = 0; i < 12; i++) begin
            bus.enable      = vecs[i].en;
            bus.duty_target = vecs[i].tgt;
            bus.step        = vecs[i].step;
            run_period(0, 12'd0, len, highs);
            check($sformatf("vec%0d_duty", i),   int'(bus.duty_now),  vecs[i].exp_duty);
            check($sformatf("vec%0d_busy", i),   int'(bus.ramp_busy), vecs[i].exp_busy);
            check($sformatf("vec%0d_active", i), int'(bus.active),    vecs[i].exp_active);
            check($sformatf("vec%0d_highs", i),  highs,               vecs[i].exp_highs);
            if (vecs[i].exp_len >= 0) begin
                check($sformatf("vec%0d_len", i), len, vecs[i].exp_len);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
